// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch core.
// Hours are only used when STOPWATCH_HOURS_EN is defined.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int SS_MAX = 59;
    localparam int HH_MAX = 23;
    localparam int SS_W   = 6;
    localparam int HH_W   = 5;

endpackage

// File: rtl/stopwatch_prescaler.sv
// Seconds prescaler: counts clk cycles while enabled and pulses tick on the last cycle of each second.
// The count is held while disabled so a resumed run finishes the partial second.
module stopwatch_prescaler #(
    parameter int CYC_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = $clog2(CYC_PER_SEC);
    localparam logic [PW-1:0] LAST = PW'(CYC_PER_SEC - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// mm:ss stopwatch with start/stop, pause, clear, lap-hold display and wrap pulse.
// Define STOPWATCH_HOURS_EN to add the hh output and carry minutes into hours.
//
// state | meaning
// IDLE  | count is zero, prescaler stopped
// RUN   | prescaler and count advancing, lap allowed
// PAUSE | count and partial second held, clear allowed
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int CYC_PER_SEC = 100_000_000,
    parameter int MM_MAX      = 59,
    parameter int MM_W        = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_stop,
    input  logic            clear,
    input  logic            lap,
    output logic [MM_W-1:0] mm,
    output logic [SS_W-1:0] ss,
    output logic            running,
    output logic            lap_hold,
    output logic            wrap
`ifdef STOPWATCH_HOURS_EN
    ,
    output logic [HH_W-1:0] hh
`endif
);

    localparam logic [SS_W-1:0] SS_LAST = SS_W'(SS_MAX);
    localparam logic [MM_W-1:0] MM_LAST = MM_W'(MM_MAX);

    state_t          state_q, state_d;
    logic            lap_hold_q, lap_hold_d;
    logic            wrap_q, wrap_d;
    logic [SS_W-1:0] cnt_ss_q, cnt_ss_d, snap_ss_q;
    logic [MM_W-1:0] cnt_mm_q, cnt_mm_d, snap_mm_q;
    logic            clr_cnt, snap_take, tick;
`ifdef STOPWATCH_HOURS_EN
    localparam logic [HH_W-1:0] HH_LAST = HH_W'(HH_MAX);
    logic [HH_W-1:0] cnt_hh_q, cnt_hh_d, snap_hh_q;
`endif

    stopwatch_prescaler #(
        .CYC_PER_SEC(CYC_PER_SEC)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (state_q == RUN),
        .clr (clr_cnt),
        .tick(tick)
    );

    // start_stop wins over lap and clear in the same cycle.
    always_comb begin
        state_d    = state_q;
        lap_hold_d = lap_hold_q;
        clr_cnt    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                if (start_stop) begin
                    state_d    = PAUSE;
                    lap_hold_d = 1'b0;
                end else if (lap) begin
                    lap_hold_d = !lap_hold_q;
                end
            end
            PAUSE: begin
                if (start_stop) begin
                    state_d = RUN;
                end else if (clear) begin
                    state_d = IDLE;
                    clr_cnt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign snap_take = (state_q == RUN) && !start_stop && lap && !lap_hold_q;

    always_comb begin
        cnt_ss_d = cnt_ss_q;
        cnt_mm_d = cnt_mm_q;
        wrap_d   = 1'b0;
`ifdef STOPWATCH_HOURS_EN
        cnt_hh_d = cnt_hh_q;
`endif
        if (clr_cnt) begin
            cnt_ss_d = '0;
            cnt_mm_d = '0;
`ifdef STOPWATCH_HOURS_EN
            cnt_hh_d = '0;
`endif
        end else if (tick) begin
            if (cnt_ss_q != SS_LAST) begin
                cnt_ss_d = cnt_ss_q + 1'b1;
            end else begin
                cnt_ss_d = '0;
                if (cnt_mm_q != MM_LAST) begin
                    cnt_mm_d = cnt_mm_q + 1'b1;
                end else begin
                    cnt_mm_d = '0;
`ifdef STOPWATCH_HOURS_EN
                    if (cnt_hh_q != HH_LAST) begin
                        cnt_hh_d = cnt_hh_q + 1'b1;
                    end else begin
                        cnt_hh_d = '0;
                        wrap_d   = 1'b1;
                    end
`else
                    wrap_d = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lap_hold_q <= 1'b0;
            wrap_q     <= 1'b0;
            cnt_ss_q   <= '0;
            cnt_mm_q   <= '0;
            snap_ss_q  <= '0;
            snap_mm_q  <= '0;
`ifdef STOPWATCH_HOURS_EN
            cnt_hh_q   <= '0;
            snap_hh_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lap_hold_q <= lap_hold_d;
            wrap_q     <= wrap_d;
            cnt_ss_q   <= cnt_ss_d;
            cnt_mm_q   <= cnt_mm_d;
`ifdef STOPWATCH_HOURS_EN
            cnt_hh_q   <= cnt_hh_d;
`endif
            // Snapshot is the value on display in the cycle lap was sampled.
            if (snap_take) begin
                snap_ss_q <= cnt_ss_q;
                snap_mm_q <= cnt_mm_q;
`ifdef STOPWATCH_HOURS_EN
                snap_hh_q <= cnt_hh_q;
`endif
            end
        end
    end

    assign ss       = lap_hold_q ? snap_ss_q : cnt_ss_q;
    assign mm       = lap_hold_q ? snap_mm_q : cnt_mm_q;
    assign running  = (state_q == RUN);
    assign lap_hold = lap_hold_q;
    assign wrap     = wrap_q;
`ifdef STOPWATCH_HOURS_EN
    assign hh       = lap_hold_q ? snap_hh_q : cnt_hh_q;
`endif

endmodule
